// File: rtl/waitstate_mem_if.sv
// Bus bundle between a CPU-side master and waitstate_mem.
// Request: MREQ MAB MDBout MW BW; response: MDBin READY HIT ERR.
interface waitstate_mem_if;
    logic        MREQ;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        MW;
    logic        BW;
    logic [15:0] MDBin;
    logic        READY;
    logic        HIT;
    logic        ERR;

    modport master (
        output MREQ, MAB, MDBout, MW, BW,
        input  MDBin, READY, HIT, ERR
    );

    modport slave (
        input  MREQ, MAB, MDBout, MW, BW,
        output MDBin, READY, HIT, ERR
    );
endinterface

// File: rtl/waitstate_mem.sv
// Byte-addressed 16-bit memory with programmable wait states.
// Ports: MCLK, reset (async, active-low), bus (waitstate_mem_if.slave).
module waitstate_mem #(
    parameter logic [15:0] BASE_ADDR   = 16'h4400,
    parameter int unsigned DEPTH_BYTES = 48128,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] FILL_WORD   = 16'h4303
) (
    input logic            MCLK,
    input logic            reset,
    waitstate_mem_if.slave bus
);
    localparam int unsigned WORDS = DEPTH_BYTES / 2;
    localparam int unsigned AW =
        (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned OW = AW + 1;
    localparam logic [16:0] LO = 17'(BASE_ADDR);
    localparam logic [16:0] HI =
        17'(BASE_ADDR) + 17'(DEPTH_BYTES);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic        mw_q;
    logic        bw_q;
    logic        ready_q;
    logic        hit_q;
    logic        err_q;
    logic [15:0] rd_q;

    // BASE_ADDR is expected to be even so that aligned byte
    // addresses map onto whole array words.
    logic [15:0] mem [WORDS] = '{default: FILL_WORD};

    logic          in_wait;
    logic          accept;
    logic          finish;
    logic [15:0]   op_a;
    logic [15:0]   op_d;
    logic          op_mw;
    logic          op_bw;
    logic [16:0]   a17;
    logic [OW-1:0] off;
    logic [AW-1:0] widx;
    logic          in_rng;
    logic          mis;
    logic          hit;
    logic          we;
    logic [15:0]   rword;
    logic [15:0]   rdata;
    logic [15:0]   rd_next;

    assign in_wait = (state == WAIT);
    assign accept  = !in_wait && bus.MREQ;

    // The access completes on the edge entering DONE: either the
    // last WAIT cycle, or the accept edge itself with no wait states.
    assign finish = in_wait ? (cnt == 4'd0)
                  : (accept && (WAIT_STATES == 0));

    // Operands come from the latch in WAIT, otherwise straight
    // from the bus (zero-wait completion on the accept edge).
    assign op_a  = in_wait ? a_q  : bus.MAB;
    assign op_d  = in_wait ? d_q  : bus.MDBout;
    assign op_mw = in_wait ? mw_q : bus.MW;
    assign op_bw = in_wait ? bw_q : bus.BW;

    assign a17  = {1'b0, op_a};
    assign off  = OW'(a17 - LO);
    assign widx = off[OW-1:1];

    assign in_rng = (a17 >= LO) && (a17 < HI)
                  && (op_bw || ((a17 + 17'd1) < HI));
    assign mis    = !op_bw && op_a[0];
    assign hit    = in_rng && !mis;
    assign we     = finish && hit && op_mw && reset;

    assign rword = mem[widx];
    assign rdata = op_bw
                 ? {8'h00, off[0] ? rword[15:8] : rword[7:0]}
                 : rword;
    assign rd_next = (hit && !op_mw) ? rdata : 16'h0000;

    always_ff @(posedge MCLK) begin
        if (we) begin
            if (!op_bw) begin
                mem[widx] <= op_d;
            end else if (off[0]) begin
                mem[widx][15:8] <= op_d[7:0];
            end else begin
                mem[widx][7:0] <= op_d[7:0];
            end
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            mw_q    <= 1'b0;
            bw_q    <= 1'b0;
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 16'h0000;
        end else begin
            ready_q <= finish;
            if (finish) begin
                hit_q <= hit;
                err_q <= mis;
                rd_q  <= rd_next;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q  <= bus.MAB;
                        d_q  <= bus.MDBout;
                        mw_q <= bus.MW;
                        bw_q <= bus.BW;
                        if (WAIT_STATES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.READY = ready_q;
    assign bus.HIT   = hit_q;
    assign bus.ERR   = err_q;
    assign bus.MDBin = rd_q;
endmodule

// File: tb/tb_waitstate_mem.sv
// Randomized bench for waitstate_mem with a byte-level model.
// Three instances: 0 and 3/256B and 5 wait states.
module tb_waitstate_mem;
    localparam int N = 3;
    localparam logic [15:0] BASE = 16'h4400;
    localparam logic [15:0] FILL = 16'h4303;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic        b;
    } op_t;

    int ws    [N] = '{0, 3, 5};
    int depth [N] = '{48128, 256, 48128};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    int          sel = 0;
    logic [15:0] mab = 16'h0000;
    logic [15:0] mdo = 16'h0000;
    logic        mw = 1'b0;
    logic        bw = 1'b0;

    logic        rdy   [N];
    logic        hit   [N];
    logic        err   [N];
    logic [15:0] mdbin [N];

    int errs = 0;
    int checks = 0;

    logic [7:0] mdl [int];
    op_t ops [$];

    always #5 clk = ~clk;

    waitstate_mem_if b0 ();
    waitstate_mem_if b1 ();
    waitstate_mem_if b2 ();

    assign b0.MREQ = req && (sel == 0);
    assign b1.MREQ = req && (sel == 1);
    assign b2.MREQ = req && (sel == 2);
    assign b0.MAB = mab;
    assign b1.MAB = mab;
    assign b2.MAB = mab;
    assign b0.MDBout = mdo;
    assign b1.MDBout = mdo;
    assign b2.MDBout = mdo;
    assign b0.MW = mw;
    assign b1.MW = mw;
    assign b2.MW = mw;
    assign b0.BW = bw;
    assign b1.BW = bw;
    assign b2.BW = bw;

    assign rdy[0] = b0.READY;
    assign rdy[1] = b1.READY;
    assign rdy[2] = b2.READY;
    assign hit[0] = b0.HIT;
    assign hit[1] = b1.HIT;
    assign hit[2] = b2.HIT;
    assign err[0] = b0.ERR;
    assign err[1] = b1.ERR;
    assign err[2] = b2.ERR;
    assign mdbin[0] = b0.MDBin;
    assign mdbin[1] = b1.MDBin;
    assign mdbin[2] = b2.MDBin;

    waitstate_mem #(
        .BASE_ADDR  (BASE),
        .DEPTH_BYTES(48128),
        .WAIT_STATES(0),
        .FILL_WORD  (FILL)
    ) u0 (
        .MCLK (clk),
        .reset(rst_n),
        .bus  (b0)
    );

    waitstate_mem #(
        .BASE_ADDR  (BASE),
        .DEPTH_BYTES(256),
        .WAIT_STATES(3),
        .FILL_WORD  (FILL)
    ) u1 (
        .MCLK (clk),
        .reset(rst_n),
        .bus  (b1)
    );

    waitstate_mem #(
        .BASE_ADDR  (BASE),
        .DEPTH_BYTES(48128),
        .WAIT_STATES(5),
        .FILL_WORD  (FILL)
    ) u2 (
        .MCLK (clk),
        .reset(rst_n),
        .bus  (b2)
    );

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rdb(input int k, input int a);
        int key = k * 65536 + a;
        if (mdl.exists(key)) return mdl[key];
        return a[0] ? FILL[15:8] : FILL[7:0];
    endfunction

    // Reference: byte-array semantics straight from the rules.
    function automatic void ref_op(input int k, input op_t o,
                                   output logic h,
                                   output logic e,
                                   output logic [15:0] r);
        int ai = int'(o.a);
        int lo = int'(BASE);
        int hi = lo + depth[k];
        e = !o.b && o.a[0];
        h = !e && ai >= lo && ai < hi
            && (o.b || ai + 1 < hi);
        r = 16'h0000;
        if (h && o.w) begin
            mdl[k * 65536 + ai] = o.d[7:0];
            if (!o.b) mdl[k * 65536 + ai + 1] = o.d[15:8];
        end
        if (h && !o.w) begin
            if (o.b) r = {8'h00, rdb(k, ai)};
            else     r = {rdb(k, ai + 1), rdb(k, ai)};
        end
    endfunction

    task automatic push(input logic [15:0] a,
                        input logic [15:0] d,
                        input logic w, input logic b);
        op_t o;
        o.a = a;
        o.d = d;
        o.w = w;
        o.b = b;
        ops.push_back(o);
    endtask

    task automatic drive(input op_t o);
        mab = o.a;
        mdo = o.d;
        mw  = o.w;
        bw  = o.b;
    endtask

    // Issues the queued ops to instance k with MREQ held high,
    // so each new op is accepted in the DONE cycle of the last.
    task automatic run(input int k);
        logic        h;
        logic        e;
        logic [15:0] r;
        int          n;
        n = ops.size();
        r = 16'h0000;
        sel = k;
        drive(ops[0]);
        req = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c <= ws[k]; c++) begin
                @(posedge clk);
                #1;
                if (c < ws[k]) chk("busy", 16'(rdy[k]), 16'h0);
            end
            ref_op(k, ops[i], h, e, r);
            chk("ready", 16'(rdy[k]), 16'h1);
            chk("hit", 16'(hit[k]), 16'(h));
            chk("err", 16'(err[k]), 16'(e));
            chk("mdbin", mdbin[k], r);
            if (i + 1 < n) drive(ops[i + 1]);
            else req = 1'b0;
        end
        ops.delete();
        @(posedge clk);
        #1;
        chk("idle_rdy", 16'(rdy[k]), 16'h0);
        chk("hold", mdbin[k], r);
    endtask

    function automatic logic [15:0] raddr(input int k);
        int e = int'(BASE) + depth[k];
        int s = int'($urandom_range(0, 6));
        if (s <= 2) return 16'(int'(BASE) + int'($urandom_range(0, 15)));
        if (s == 3) return 16'(e - 2 + int'($urandom_range(0, 3)));
        if (s == 4) return $urandom_range(0, 1) ? 16'h43FF : 16'h0200;
        return 16'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        for (int k = 0; k < N; k++) begin
            chk("rst_rdy", 16'(rdy[k]), 16'h0);
            chk("rst_mdbin", mdbin[k], 16'h0000);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // zero-wait word read of the fill pattern
        push(16'h4400, 16'h0000, 1'b0, 1'b0);
        run(0);
        // 3-wait word write then byte read of its high half
        push(16'h4410, 16'hA5A5, 1'b1, 1'b0);
        run(1);
        push(16'h4411, 16'h0000, 1'b0, 1'b1);
        run(1);
        // back-to-back writes and reads incl. read-after-write
        push(16'h4420, 16'h1234, 1'b1, 1'b0);
        push(16'h4420, 16'h0000, 1'b0, 1'b0);
        push(16'h4421, 16'h00EE, 1'b1, 1'b1);
        push(16'h4420, 16'h0000, 1'b0, 1'b0);
        run(0);
        push(16'h4400, 16'h0000, 1'b0, 1'b0);
        push(16'h4402, 16'h0000, 1'b0, 1'b0);
        push(16'h4420, 16'h0000, 1'b0, 1'b1);
        push(16'h4421, 16'h0000, 1'b0, 1'b1);
        run(0);
        // misaligned and out-of-range accesses
        push(16'h4401, 16'h0000, 1'b0, 1'b0);
        push(16'h4401, 16'hDEAD, 1'b1, 1'b0);
        push(16'h4400, 16'h0000, 1'b0, 1'b0);
        push(16'h0200, 16'h0000, 1'b0, 1'b0);
        push(16'hFFFF, 16'hBEEF, 1'b1, 1'b0);
        push(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        push(16'hFFFE, 16'h0000, 1'b0, 1'b0);
        run(0);
        // end of the 256-byte window
        push(16'h44FE, 16'h7788, 1'b1, 1'b0);
        push(16'h4500, 16'h5555, 1'b1, 1'b0);
        push(16'h44FE, 16'h0000, 1'b0, 1'b0);
        run(1);

        // reset while a 5-wait write is pending
        push(16'h4400, 16'h0000, 1'b0, 1'b0);
        run(2);
        sel = 2;
        mab = 16'h4430;
        mdo = 16'hBEEF;
        mw  = 1'b1;
        bw  = 1'b0;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", 16'(rdy[2]), 16'h0);
        chk("arst_hit", 16'(hit[2]), 16'h0);
        chk("arst_err", 16'(err[2]), 16'h0);
        chk("arst_mdbin", mdbin[2], 16'h0000);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) rst_n = 1'b1;
            chk("no_ready", 16'(rdy[2]), 16'h0);
        end
        push(16'h4430, 16'h0000, 1'b0, 1'b0);
        run(2);
        push(16'h4420, 16'h0000, 1'b0, 1'b0);
        run(0);

        for (int t = 0; t < 80; t++) begin
            int k = int'($urandom_range(0, N - 1));
            int n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                push(raddr(k), 16'($urandom),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end
            run(k);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/waitstate_mem.md
WAITSTATE_MEM -- requirements
Module: waitstate_mem

Interface
REQ-001 Parameter BASE_ADDR, default 16'h4400: lowest byte address decoded by the block.
REQ-002 Parameter DEPTH_BYTES, default 48128: decoded bytes from BASE_ADDR upward; SHALL be even, and BASE_ADDR+DEPTH_BYTES SHALL be <= 17'h1_0000.
REQ-003 Parameter WAIT_STATES, default 0: extra cycles per access; legal range 0..15.
REQ-004 Parameter FILL_WORD, default 16'h4303: simulation-time initial content of every aligned word.
REQ-005 MCLK  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 MREQ  input  1  access request, sampled on the rising edge.
REQ-008 MAB  input  16  byte address.
REQ-009 MDBout  input  16  write data from the CPU; for byte writes only [7:0] is used.
REQ-010 MW  input  1  1 = write, 0 = read.
REQ-011 BW  input  1  1 = byte access, 0 = word access.
REQ-012 MDBin  output  16  registered read data to the CPU.
REQ-013 READY  output  1  one-cycle completion strobe.
REQ-014 HIT  output  1  completed access was in range; valid while READY=1.
REQ-015 ERR  output  1  completed access was a misaligned word access; valid while READY=1.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-017 In IDLE or DONE, MREQ=1 SHALL accept a request: latch MAB, MDBout, MW and BW, then go to WAIT with the counter set to WAIT_STATES-1, or go straight to DONE when WAIT_STATES=0.
REQ-018 In IDLE, MREQ=0 SHALL keep the state; in DONE, MREQ=0 SHALL return the FSM to IDLE.
REQ-019 WAIT SHALL decrement the counter each cycle and go to DONE on the edge where the counter equals 0.
REQ-020 MREQ, MAB, MDBout, MW and BW SHALL be ignored while in WAIT; requests SHALL NOT queue.
REQ-021 READY SHALL be 1 during exactly one cycle per accepted request, in DONE; latency from the accept edge to READY high SHALL be WAIT_STATES+1 cycles.
REQ-022 Back-to-back: MREQ=1 in every DONE cycle SHALL give one completion every WAIT_STATES+1 cycles (every cycle when WAIT_STATES=0).
REQ-023 In range SHALL mean BASE_ADDR <= addr < BASE_ADDR+DEPTH_BYTES; for a word access, addr+1 SHALL also be in range.
REQ-024 Misaligned SHALL mean BW=0 and addr[0]=1; the access SHALL set ERR=1 and HIT=0, suppress any write, and return MDBin=16'h0000.
REQ-025 Out of range: HIT=0, ERR=0, write suppressed, MDBin=16'h0000.
REQ-026 An in-range word read SHALL return {mem[a+1], mem[a]} (little-endian); an in-range byte read SHALL return {8'h00, mem[a]}.
REQ-027 An in-range word write SHALL store MDBout[7:0] to mem[a] and MDBout[15:8] to mem[a+1]; a byte write SHALL store MDBout[7:0] to mem[a] only.
REQ-028 Writes SHALL commit on the edge entering DONE; MDBin SHALL read 16'h0000 on a write completion.
REQ-029 A read completing in the cycle after a write to the same address SHALL return the newly written data.
REQ-030 MDBin SHALL hold its last value whenever READY=0.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, counter 0, READY=0, HIT=0, ERR=0 and MDBin=16'h0000.
REQ-032 Reset SHALL NOT alter the memory array; a write still in WAIT when reset is asserted SHALL be discarded.
REQ-033 The first request SHALL be accepted on the first rising edge at which reset=1 and MREQ=1.

Verification
REQ-034 WAIT_STATES=0, read word at 16'h4400 after init -> READY on the next cycle, MDBin=16'h4303, HIT=1, ERR=0.
REQ-035 WAIT_STATES=3, word write of 16'hA5A5 to 16'h4410, then a byte read at 16'h4411 -> each READY 4 cycles after its accept edge, read MDBin=16'h00A5.
REQ-036 WAIT_STATES=0, MREQ held high for 4 consecutive reads -> READY=1 for 4 consecutive cycles with correct data each cycle.
REQ-037 Word read at 16'h4401 -> ERR=1, HIT=0, MDBin=16'h0000; word write at 16'h4401 -> memory unchanged.
REQ-038 Read at 16'h0200 and word write at 16'hFFFF with the default parameters -> HIT=0, MDBin=16'h0000, no memory change.
REQ-039 WAIT_STATES=5, reset=0 pulsed two cycles after a write is accepted -> no READY, target word unchanged, next request behaves normally.
